// File: rtl/priv_hpm_scheduler.sv
// Programmable HPM scheduler: maps per-cycle event pulses onto selectable counters
// with inhibit, CSR load/read and sticky overflow. Optional PRIV_HPM_OVF_IRQ_EN adds irq + freeze-on-overflow.
module priv_hpm_scheduler #(
    parameter int NUM_COUNTERS = 4,
    parameter int NUM_EVENTS   = 32,
    parameter int CNT_WIDTH    = 64
) (
    input  logic                            CLK,
    input  logic                            nRST,
    input  logic [NUM_EVENTS-1:0]           event_vec,
    input  logic [NUM_COUNTERS-1:0]         inhibit,
    input  logic                            sel_we,
    input  logic [$clog2(NUM_COUNTERS)-1:0] sel_idx,
    input  logic [$clog2(NUM_EVENTS)-1:0]   sel_wdata,
    input  logic                            cnt_we,
    input  logic [$clog2(NUM_COUNTERS)-1:0] cnt_idx,
    input  logic [CNT_WIDTH-1:0]            cnt_wdata,
    input  logic                            rd_en,
    input  logic [$clog2(NUM_COUNTERS)-1:0] rd_idx,
    output logic [CNT_WIDTH-1:0]            rd_data,
    output logic [$clog2(NUM_EVENTS)-1:0]   rd_sel,
    output logic                            rd_valid,
    output logic [NUM_COUNTERS-1:0]         ovf,
    input  logic [NUM_COUNTERS-1:0]         ovf_clr,
    output logic                            ovf_irq
);

    localparam int IDX_W = $clog2(NUM_COUNTERS);
    localparam int SEL_W = $clog2(NUM_EVENTS);
    localparam logic [SEL_W:0] EVT_LIM = (SEL_W + 1)'(NUM_EVENTS);

    logic [CNT_WIDTH-1:0]    cnt_q [NUM_COUNTERS];
    logic [CNT_WIDTH-1:0]    cnt_d [NUM_COUNTERS];
    logic [SEL_W-1:0]        sel_q [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] ovf_q, ovf_d;
    logic [NUM_COUNTERS-1:0] hit, wr_hit, inc, wrap, frozen;
    logic                    rd_valid_q;
    logic [CNT_WIDTH-1:0]    rd_data_q;
    logic [SEL_W-1:0]        rd_sel_q;

    // NOTE: every variable driven here gets a default before any condition,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            hit[i] = 1'b0;
            if (sel_q[i] != '0 && {1'b0, sel_q[i]} < EVT_LIM)
                hit[i] = event_vec[sel_q[i]];
            wr_hit[i] = cnt_we && (cnt_idx == IDX_W'(i));
            inc[i]    = hit[i] & ~inhibit[i] & ~wr_hit[i] & ~frozen[i];
            wrap[i]   = inc[i] & (&cnt_q[i]);
            // A write wins over a same-cycle increment; the lost event is dropped.
            if (wr_hit[i])
                cnt_d[i] = cnt_wdata;
            else if (inc[i])
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            else
                cnt_d[i] = cnt_q[i];
            // Setting by a wrap beats a coincident clear.
            ovf_d[i] = wrap[i] | (ovf_q[i] & ~ovf_clr[i]);
        end
    end

    // NOTE: the counter/selector arrays are architectural state that must read
    // as zero after reset, so unlike a data buffer they are explicitly reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge state, which is what makes reads return pre-update values.
            for (int i = 0; i < NUM_COUNTERS; i++)
                cnt_q[i] <= cnt_d[i];
            if (sel_we)
                sel_q[sel_idx] <= sel_wdata;
            ovf_q <= ovf_d;
        end
    end

    // Read port: one-cycle pulse, data holds between reads.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_sel_q   <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= cnt_q[rd_idx];
                rd_sel_q  <= sel_q[rd_idx];
            end
        end
    end

`ifdef PRIV_HPM_OVF_IRQ_EN
    logic [NUM_COUNTERS-1:0] frz_q;
    logic                    irq_q;

    // Freeze is tracked apart from ovf so a counter write can release it
    // without clearing the sticky flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            frz_q <= '0;
            irq_q <= 1'b0;
        end else begin
            frz_q <= wrap | (frz_q & ~ovf_clr & ~wr_hit);
            irq_q <= |ovf_q;
        end
    end

    assign frozen  = frz_q;
    assign ovf_irq = irq_q;
`else
    assign frozen  = '0;
    assign ovf_irq = 1'b0;
`endif

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_sel   = rd_sel_q;
    assign ovf      = ovf_q;

endmodule
